// File: rtl/csi_pkg.sv
// Shared definitions for the CSI-2 packet sequencer: FSM states, short-packet
// threshold, byte-enable encodings and header field offsets.
package csi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_PAYLOAD,
    ST_CRC_FULL,
    ST_CRC_HI,
    ST_WAIT_EOT
  } state_t;

  localparam logic [5:0] CSI_SHORT_DT_MAX = 6'h0F;

  localparam logic [1:0] KEEP_BOTH = 2'b11;
  localparam logic [1:0] KEEP_HI   = 2'b10;

  localparam int unsigned DATA_ID_LSB = 0;
  localparam int unsigned DATA_ID_MSB = 7;
  localparam int unsigned WC_LSB      = 8;
  localparam int unsigned WC_MSB      = 23;
  localparam int unsigned ECC_LSB     = 24;
  localparam int unsigned ECC_MSB     = 31;

  function automatic logic is_short_dt(input logic [7:0] data_id);
    return data_id[5:0] <= CSI_SHORT_DT_MAX;
  endfunction

endpackage

// File: rtl/csi_byte_counter.sv
// Remaining-payload-byte counter: loaded with the word count, decremented by
// two per payload word, flags the final full or half word.
module csi_byte_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        last_full,
  output logic        last_half
);

  logic [15:0] rem;

  // Saturating decrement keeps rem from wrapping even if dec arrives at rem < 2.
  always_ff @(posedge clk) begin
    if (!reset_n)
      rem <= '0;
    else if (load)
      rem <= load_val;
    else if (dec)
      rem <= (rem >= 16'd2) ? rem - 16'd2 : '0;
  end

  assign last_full = (rem == 16'd2);
  assign last_half = (rem == 16'd1);

endmodule

// File: rtl/csi_packet_sequencer.sv
// Per-burst packet sequencer: arms the header finder, latches the header and
// splits the following stream into payload words and the 16-bit CRC footer.
module csi_packet_sequencer
  import csi_pkg::*;
(
  input  logic        rxbyteclkhs,
  input  logic        reset_n,
  input  logic        lane_active,
  input  logic [31:0] ph_dout,
  input  logic        ph_valid,
  input  logic        ph_select,
  output logic        finder_en,
  output logic [7:0]  hdr_data_id,
  output logic [15:0] hdr_wc,
  output logic [7:0]  hdr_ecc,
  output logic        hdr_valid,
  output logic        short_pkt,
  output logic [15:0] pay_data,
  output logic [1:0]  pay_keep,
  output logic        pay_valid,
  output logic        pay_last,
  output logic [15:0] crc_data,
  output logic        crc_valid,
  output logic        pkt_done,
  output logic        pkt_err
);

  state_t state, next_state;

  logic        cnt_load, cnt_dec, last_full, last_half;
  logic [7:0]  crc_lsb, crc_lsb_d;
  logic        finder_en_d, hdr_valid_d, short_pkt_d, pay_valid_d, pay_last_d;
  logic        crc_valid_d, pkt_done_d, pkt_err_d;
  logic [7:0]  hdr_data_id_d, hdr_ecc_d;
  logic [15:0] hdr_wc_d, pay_data_d, crc_data_d;
  logic [1:0]  pay_keep_d;
  logic        drop;

  assign drop = !lane_active || !ph_valid;

  csi_byte_counter u_counter (
    .clk      (rxbyteclkhs),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (ph_dout[WC_MSB:WC_LSB]),
    .dec      (cnt_dec),
    .last_full(last_full),
    .last_half(last_half)
  );

  always_comb begin
    next_state    = state;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    crc_lsb_d     = crc_lsb;
    hdr_data_id_d = hdr_data_id;
    hdr_wc_d      = hdr_wc;
    hdr_ecc_d     = hdr_ecc;
    short_pkt_d   = short_pkt;
    pay_data_d    = pay_data;
    pay_keep_d    = pay_keep;
    crc_data_d    = crc_data;
    hdr_valid_d   = 1'b0;
    pay_valid_d   = 1'b0;
    pay_last_d    = 1'b0;
    crc_valid_d   = 1'b0;
    pkt_done_d    = 1'b0;
    pkt_err_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (lane_active) next_state = ST_HUNT;
      end
      ST_HUNT: begin
        if (!lane_active) begin
          next_state = ST_IDLE;
        end else if (ph_valid && ph_select) begin
          hdr_data_id_d = ph_dout[DATA_ID_MSB:DATA_ID_LSB];
          hdr_wc_d      = ph_dout[WC_MSB:WC_LSB];
          hdr_ecc_d     = ph_dout[ECC_MSB:ECC_LSB];
          short_pkt_d   = is_short_dt(ph_dout[DATA_ID_MSB:DATA_ID_LSB]);
          hdr_valid_d   = 1'b1;
          if (short_pkt_d) begin
            pkt_done_d = 1'b1;
            next_state = ST_WAIT_EOT;
          end else if (hdr_wc_d == 16'd0) begin
            next_state = ST_CRC_FULL;
          end else begin
            cnt_load   = 1'b1;
            next_state = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (drop) begin
          pkt_err_d  = 1'b1;
          next_state = ST_IDLE;
        end else begin
          pay_valid_d = 1'b1;
          pay_data_d  = ph_dout[31:16];
          if (last_half) begin
            pay_keep_d = KEEP_HI;
            pay_last_d = 1'b1;
            crc_lsb_d  = ph_dout[23:16];
            next_state = ST_CRC_HI;
          end else if (last_full) begin
            pay_keep_d = KEEP_BOTH;
            pay_last_d = 1'b1;
            next_state = ST_CRC_FULL;
          end else begin
            pay_keep_d = KEEP_BOTH;
            cnt_dec    = 1'b1;
          end
        end
      end
      ST_CRC_FULL, ST_CRC_HI: begin
        if (drop) begin
          pkt_err_d  = 1'b1;
          next_state = ST_IDLE;
        end else begin
          crc_data_d  = (state == ST_CRC_FULL) ? {ph_dout[23:16], ph_dout[31:24]}
                                               : {ph_dout[31:24], crc_lsb};
          crc_valid_d = 1'b1;
          pkt_done_d  = 1'b1;
          next_state  = ST_WAIT_EOT;
        end
      end
      ST_WAIT_EOT: begin
        if (!lane_active) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    // Registered from next_state so finder_en tracks the state register exactly.
    finder_en_d = (next_state == ST_HUNT) || (next_state == ST_PAYLOAD) ||
                  (next_state == ST_CRC_FULL) || (next_state == ST_CRC_HI);
  end

  always_ff @(posedge rxbyteclkhs) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      crc_lsb     <= '0;
      finder_en   <= 1'b0;
      hdr_data_id <= '0;
      hdr_wc      <= '0;
      hdr_ecc     <= '0;
      hdr_valid   <= 1'b0;
      short_pkt   <= 1'b0;
      pay_data    <= '0;
      pay_keep    <= '0;
      pay_valid   <= 1'b0;
      pay_last    <= 1'b0;
      crc_data    <= '0;
      crc_valid   <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
    end else begin
      state       <= next_state;
      crc_lsb     <= crc_lsb_d;
      finder_en   <= finder_en_d;
      hdr_data_id <= hdr_data_id_d;
      hdr_wc      <= hdr_wc_d;
      hdr_ecc     <= hdr_ecc_d;
      hdr_valid   <= hdr_valid_d;
      short_pkt   <= short_pkt_d;
      pay_data    <= pay_data_d;
      pay_keep    <= pay_keep_d;
      pay_valid   <= pay_valid_d;
      pay_last    <= pay_last_d;
      crc_data    <= crc_data_d;
      crc_valid   <= crc_valid_d;
      pkt_done    <= pkt_done_d;
      pkt_err     <= pkt_err_d;
    end
  end

endmodule

// File: tb/tb_csi_packet_sequencer.sv
// Randomized bench for csi_packet_sequencer: each burst is described as a byte
// stream and the expected header/payload/CRC events are derived from it.
module tb_csi_packet_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, lane_active, ph_valid, ph_select;
  logic [31:0] ph_dout;
  logic        finder_en, hdr_valid, short_pkt, pay_valid, pay_last;
  logic        crc_valid, pkt_done, pkt_err;
  logic [7:0]  hdr_data_id, hdr_ecc;
  logic [15:0] hdr_wc, pay_data, crc_data;
  logic [1:0]  pay_keep;

  always #5 clk = ~clk;

  csi_packet_sequencer dut (
    .rxbyteclkhs(clk),
    .reset_n    (reset_n),
    .lane_active(lane_active),
    .ph_dout    (ph_dout),
    .ph_valid   (ph_valid),
    .ph_select  (ph_select),
    .finder_en  (finder_en),
    .hdr_data_id(hdr_data_id),
    .hdr_wc     (hdr_wc),
    .hdr_ecc    (hdr_ecc),
    .hdr_valid  (hdr_valid),
    .short_pkt  (short_pkt),
    .pay_data   (pay_data),
    .pay_keep   (pay_keep),
    .pay_valid  (pay_valid),
    .pay_last   (pay_last),
    .crc_data   (crc_data),
    .crc_valid  (crc_valid),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: samples on the falling edge, counters only ever grow.
  int          cyc = 0;
  int          hdr_cnt = 0, done_cnt = 0, err_cnt = 0, overlap_cnt = 0, hdr_cyc = 0;
  logic [31:0] got_hdr;
  logic        got_short;
  logic [18:0] got_pay[$];
  logic [15:0] got_crc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hdr_valid) begin
      hdr_cnt++;
      hdr_cyc   = cyc;
      got_hdr   = {hdr_ecc, hdr_wc, hdr_data_id};
      got_short = short_pkt;
    end
    if (pay_valid) got_pay.push_back({pay_data, pay_keep, pay_last});
    if (crc_valid) got_crc.push_back(crc_data);
    if (pkt_done) done_cnt++;
    if (pkt_err) err_cnt++;
    if (pay_valid && crc_valid) overlap_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [73:0] all_out;
  assign all_out = {finder_en, hdr_data_id, hdr_wc, hdr_ecc, hdr_valid, short_pkt,
                    pay_data, pay_keep, pay_valid, pay_last, crc_data, crc_valid,
                    pkt_done, pkt_err};

  // trunc_k < 0: complete packet; otherwise drop after trunc_k stream words
  // (mode 0: lane_active falls, mode 1: ph_valid falls). pattern selects the
  // fixed 11 22 33 .. payload with CRC bytes AB (first) CD.
  task automatic run_burst(input string name, input logic [7:0] dt, input logic [15:0] wc,
                           input int trunc_k, input int trunc_mode, input bit pattern);
    int   b_hdr, b_done, b_err, b_ovl, b_pay, b_crc, t, nbytes, nwords, npay, limit;
    int   hdr_drive;
    bit   is_short, trunc;
    logic [7:0] ecc, crc_lo, crc_hi;
    logic [7:0] bytes[];
    logic [18:0] exp_w;
    b_hdr = hdr_cnt; b_done = done_cnt; b_err = err_cnt; b_ovl = overlap_cnt;
    b_pay = got_pay.size(); b_crc = got_crc.size();
    is_short = (dt[5:0] < 6'h10);
    trunc    = (trunc_k >= 0);
    ecc      = 8'($urandom);
    crc_lo   = pattern ? 8'hAB : 8'($urandom);
    crc_hi   = pattern ? 8'hCD : 8'($urandom);
    npay     = is_short ? 0 : (int'(wc) + 1) / 2;
    nwords   = is_short ? 0 : (int'(wc) + 3) / 2;
    nbytes   = 2 * nwords + 2;
    bytes    = new[nbytes];
    for (int i = 0; i < nbytes; i++) bytes[i] = 8'($urandom);
    if (!is_short) begin
      for (int i = 0; i < int'(wc); i++) if (pattern) bytes[i] = 8'((i % 15 + 1) * 17);
      bytes[wc]     = crc_lo;
      bytes[wc + 1] = crc_hi;
    end

    lane_active = 1'b1; ph_valid = 1'b0; ph_select = 1'b0; ph_dout = $urandom;
    t = 0;
    do begin step(); t++; end while (!finder_en && t < 8);
    check({name, ":finder_en_latency"}, t, 1);
    repeat ($urandom_range(0, 3)) step();

    ph_dout = {ecc, wc, dt}; ph_valid = 1'b1; ph_select = 1'b1;
    hdr_drive = cyc;
    step();
    ph_select = 1'b0;
    limit = trunc ? trunc_k : nwords;
    for (int i = 0; i < limit; i++) begin
      ph_dout = {bytes[2*i], bytes[2*i+1], 16'($urandom)};
      step();
    end
    if (trunc) begin
      if (trunc_mode == 0) lane_active = 1'b0;
      else ph_valid = 1'b0;
      ph_dout = $urandom;
      step();
      ph_valid = 1'b0;
    end else begin
      ph_valid = 1'($urandom); ph_dout = $urandom;
      step();
      check({name, ":finder_en_after_pkt"}, finder_en, 0);
      repeat (2) begin ph_valid = 1'($urandom); ph_dout = $urandom; step(); end
    end
    lane_active = 1'b0; ph_valid = 1'b0;
    repeat (3) step();
    check({name, ":finder_en_idle"}, finder_en, 0);

    check({name, ":hdr_count"}, hdr_cnt - b_hdr, 1);
    check({name, ":hdr_fields"}, got_hdr, {ecc, wc, dt});
    check({name, ":short_pkt"}, got_short, is_short);
    check({name, ":hdr_latency"}, hdr_cyc - hdr_drive, 1);
    check({name, ":pay_count"}, got_pay.size() - b_pay, trunc ? trunc_k : npay);
    for (int i = 0; i < npay && b_pay + i < got_pay.size(); i++) begin
      exp_w = {bytes[2*i], bytes[2*i+1], (2*i + 1 < int'(wc)) ? 2'b11 : 2'b10,
               1'(!trunc && i == npay - 1)};
      check($sformatf("%s:pay_word%0d", name, i), got_pay[b_pay + i], exp_w);
    end
    check({name, ":crc_count"}, got_crc.size() - b_crc, (trunc || is_short) ? 0 : 1);
    if (got_crc.size() > b_crc) check({name, ":crc_data"}, got_crc[b_crc], {crc_hi, crc_lo});
    check({name, ":pkt_done"}, done_cnt - b_done, trunc ? 0 : 1);
    check({name, ":pkt_err"}, err_cnt - b_err, trunc ? 1 : 0);
    check({name, ":pay_crc_overlap"}, overlap_cnt - b_ovl, 0);
  endtask

  task automatic reset_mid_payload();
    int b_err;
    b_err = err_cnt;
    lane_active = 1'b1; ph_valid = 1'b0; ph_select = 1'b0;
    repeat (2) step();
    ph_dout = {8'h5A, 16'd8, 8'h2B}; ph_valid = 1'b1; ph_select = 1'b1;
    step();
    ph_select = 1'b0;
    repeat (2) begin ph_dout = $urandom; step(); end
    check("rst_mid:in_payload", finder_en, 1);
    reset_n = 1'b0;
    step();
    check("rst_mid:outputs_zero", 32'(|all_out), 0);
    check("rst_mid:hdr_wc_zero", hdr_wc, 0);
    reset_n = 1'b1; lane_active = 1'b0; ph_valid = 1'b0;
    repeat (3) step();
    check("rst_mid:no_pkt_err", err_cnt - b_err, 0);
  endtask

  initial begin
    logic [7:0]  dt;
    logic [15:0] wc;
    int          tk, npay;
    reset_n = 1'b0; lane_active = 1'b0; ph_valid = 1'b0; ph_select = 1'b0; ph_dout = '0;
    repeat (3) step();
    check("reset:outputs_zero", 32'(|all_out), 0);
    reset_n = 1'b1;
    step();

    run_burst("short_0x00", 8'h00, 16'h1234, -1, 0, 1'b0);
    run_burst("long_wc6", 8'h2A, 16'd6, -1, 0, 1'b1);
    run_burst("long_wc3", 8'h2A, 16'd3, -1, 0, 1'b1);
    run_burst("long_wc0", 8'h2A, 16'd0, -1, 0, 1'b0);
    run_burst("trunc_lane", 8'h2A, 16'd8, 2, 0, 1'b1);
    run_burst("after_trunc", 8'h2B, 16'd5, -1, 0, 1'b0);
    run_burst("trunc_valid", 8'h24, 16'd7, 1, 1, 1'b0);
    run_burst("trunc_wc0_crc", 8'h2A, 16'd0, 0, 0, 1'b0);
    run_burst("short_dt0f", 8'hCF, 16'hBEEF, -1, 0, 1'b0);
    run_burst("long_dt10", 8'h10, 16'd1, -1, 0, 1'b0);
    reset_mid_payload();
    run_burst("after_reset", 8'h2A, 16'd4, -1, 0, 1'b1);
    run_burst("wc_ffff", 8'h2A, 16'hFFFF, -1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 3) dt = {2'($urandom), 2'b00, 4'($urandom)};
      else dt = {2'($urandom), 6'($urandom_range(16, 63))};
      wc = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(25, 300)) : 16'($urandom_range(0, 24));
      npay = (int'(wc) + 1) / 2;
      tk = -1;
      if (dt[5:0] >= 6'h10 && $urandom_range(0, 3) == 0)
        tk = (npay == 0) ? 0 : $urandom_range(0, npay - 1);
      run_burst($sformatf("rnd%0d", n), dt, wc, tk, $urandom_range(0, 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csi_packet_sequencer.md
# csi_packet_sequencer

Controls the two-lane packet-header finder that sits after the lane aligners. It arms the finder at the start of each high-speed burst and latches the packet header. For long packets it counts the payload bytes against the word count, separates out the 16-bit packet footer (CRC), and then waits for end-of-transmission before re-arming. It presents a clean header / payload / CRC stream to the downstream ECC check, CRC check and pixel unpacker.

## Interface
- No parameters. Lane count is fixed at 2. Byte order on every 16-bit word is [15:8] = first byte (lane 0), [7:0] = second byte (lane 1).
- rxbyteclkhs  in  1  byte clock; sole clock.
- reset_n  in  1  synchronous, active-low reset.
- lane_active  in  1  both lanes aligned and in HS receive; deasserts at EoT.
- ph_dout  in  32  finder output:
  - header as {ECC, WC_MSB, WC_LSB, DATA_ID};
  - thereafter, stream word in [31:16].
- ph_valid  in  1  finder dout_valid.
- ph_select  in  1  finder flag: ph_dout holds the header.
- finder_en  out  1  gates the finder's din_valid. Low holds the finder in its reset/hunt state.
- hdr_data_id  out  8  latched DATA_ID.
- hdr_wc  out  16  latched word count (short packet: the data field).
- hdr_ecc  out  8  latched ECC byte, unchecked.
- hdr_valid  out  1  one-cycle pulse when the hdr_* fields update.
- short_pkt  out  1  qualifies hdr_valid: DATA_ID[5:0] < 0x10.
- pay_data  out  16  payload word.
- pay_keep  out  2  byte enables: 2'b11 = both bytes, 2'b10 = [15:8] only.
- pay_valid  out  1  payload word strobe.
- pay_last  out  1  with pay_valid: final payload word.
- crc_data  out  16  received CRC, {MSB, LSB}; LSB is the byte transmitted first.
- crc_valid  out  1  one-cycle pulse.
- pkt_done  out  1  one-cycle pulse: packet completed normally.
- pkt_err  out  1  one-cycle pulse: lane_active or ph_valid was lost before completion.

## Operation
- **States:** IDLE, HUNT, PAYLOAD, CRC_FULL, CRC_HI, WAIT_EOT.
- **IDLE:** finder_en = 0. When lane_active = 1, go to HUNT.
- **HUNT:** finder_en = 1.
  - On ph_valid & ph_select: latch the header and pulse hdr_valid.
  - Short packet: pulse pkt_done with hdr_valid, go to WAIT_EOT.
  - Long packet with WC = 0: go to CRC_FULL.
  - Long packet otherwise: load rem = WC and go to PAYLOAD.
- **PAYLOAD:** on each ph_valid cycle, pay_data = ph_dout[31:16].
  - rem > 2: keep 11, rem -= 2.
  - rem = 2: keep 11, pay_last, go to CRC_FULL.
  - rem = 1: keep 10, pay_last, save ph_dout[23:16] as CRC LSB, go to CRC_HI.
- **CRC_FULL:** next word gives crc_data = {ph_dout[23:16], ph_dout[31:24]}. Pulse crc_valid and pkt_done, go to WAIT_EOT.
- **CRC_HI:** next word gives crc_data = {ph_dout[31:24], saved LSB}. Pulse crc_valid and pkt_done, go to WAIT_EOT.
- **WAIT_EOT:** finder_en = 0. All data is ignored (filler/trailer). When lane_active = 0, go to IDLE.
- **Scope:** one packet per HS burst.
- **Truncation:** in PAYLOAD, CRC_FULL or CRC_HI, if lane_active = 0 or ph_valid = 0, pulse pkt_err and go to IDLE.
  - No pay_last and no crc_valid are issued for that packet.
  - A drop in HUNT returns to IDLE silently.
- **Arithmetic:** rem is a 16-bit unsigned counter and must never underflow. WC = 0xFFFF runs 32767 full words plus one keep-10 word.

## Timing
- **Reset:** while reset_n = 0 at an edge, state goes to IDLE and every output is 0 on the next cycle (including crc_data, hdr_*, pay_data).
  - Reset asserted mid-packet aborts without pkt_err.
- **finder_en** is registered and is 1 exactly while the state is HUNT, PAYLOAD, CRC_FULL or CRC_HI.
  - The finder sees its first valid word two edges after lane_active rises.
- **Latency:** all outputs are registered, one cycle after the qualifying ph_* inputs.
  - hdr_valid follows the header cycle by 1.
  - The first pay_valid follows the first bypass word by 1.
- **Strobes:** pay_valid, crc_valid, hdr_valid, pkt_done and pkt_err are single-cycle pulses.
  - pay_valid is never asserted in the same cycle as crc_valid.
- **Outside strobes:** data outputs hold their last value.

## Structure
- Shared package csi_pkg holds:
  - state encodings;
  - CSI_SHORT_DT_MAX = 6'h0F;
  - keep encodings KEEP_BOTH = 2'b11, KEEP_HI = 2'b10;
  - header field offsets (DATA_ID 7:0, WC 23:8, ECC 31:24).
- One sub-module is natural: csi_byte_counter. It loads WC, decrements by 2 per word, and outputs last_full / last_half flags. The FSM lives in csi_packet_sequencer.

## Test plan
- Short packet DATA_ID 0x00, WC 0x1234 -> hdr_valid, short_pkt = 1, hdr_wc = 0x1234, pkt_done in the same cycle, no pay_valid, finder_en drops; IDLE after lane_active falls.
- Long DT 0x2A, WC = 6, payload 11 22 33 44 55 66, CRC bytes AB CD -> three pay_valid words 0x1122, 0x3344, 0x5566 (keep 11, last on the third), then crc_data = 0xCDAB, pkt_done.
- WC = 3, payload 11 22 33, CRC AB CD -> pay words 0x1122 (keep 11) and 0x33xx (keep 10, last), then crc_data = 0xCDAB.
- WC = 0 long packet -> no pay_valid; the first word after the header yields crc_valid.
- lane_active drops after 2 of 4 payload words -> pkt_err pulse, no pay_last, no crc_valid, state IDLE; the next burst is parsed correctly.
- reset_n low during PAYLOAD -> all outputs 0 next cycle, finder_en = 0, no pkt_err.
